useq: RTL and testbench

Microcode sequencer: the initiator side of the microcode ROM interface. It accepts a macro-instruction dispatch carrying a microcode entry address, drives `uPC` into the combinational microcode ROM, and interprets each returned `u_instruction`. It resolves branch and end micro-ops itself and issues all other micro-ops to the datapath over a valid/ready handshake. It sits between the macro decoder and the execute datapath.

---
 rtl/useq_if.sv | 32 +++
 rtl/useq.sv | 127 ++++++++++++
 tb/tb_useq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/useq_if.sv
// Sequencer-side bundle: macro-op dispatch, microcode ROM port, micro-op
// handshake to the datapath, datapath condition flags and routine status.
interface useq_if;
    logic        dispatch_valid;
    logic [31:0] dispatch_entry;
    logic        dispatch_ready;
    logic [31:0] uPC;
    logic [31:0] u_instruction;
    logic        uop_valid;
    logic [31:0] uop;
    logic        uop_ready;
    logic        flags_valid;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  dispatch_valid, dispatch_entry, u_instruction, uop_ready,
               flags_valid, flag_z, flag_n, flag_c, flag_v,
        output dispatch_ready, uPC, uop_valid, uop, busy, done, err
    );

    modport slave (
        output dispatch_valid, dispatch_entry, u_instruction, uop_ready,
               flags_valid, flag_z, flag_n, flag_c, flag_v,
        input  dispatch_ready, uPC, uop_valid, uop, busy, done, err
    );
endinterface

// File: rtl/useq.sv
// Microcode sequencer: walks the microcode ROM from a dispatched entry, resolves
// UBR/UEND locally, issues other micro-ops. USEQ_WATCHDOG_EN builds the abort timer.
// state | meaning: IDLE wait for dispatch | RUN walk ROM | DONE one-cycle done pulse
module useq
`ifdef USEQ_WATCHDOG_EN
#(
    parameter int WDOG_LIMIT = 1024
)
`endif
(
    input  logic   clk,
    input  logic   rst,
    useq_if.master bus
);
    localparam logic [7:0] OP_UEND = 8'hD0;
    localparam logic [7:0] OP_UBR  = 8'hC2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [31:0] uPcNext;
    logic [31:0] uPcInc;
    logic [31:0] offExt;
    logic [7:0]  op;
    logic [3:0]  cond;
    logic        taken;
    logic        wdogHit;

    assign op     = bus.u_instruction[31:24];
    assign cond   = bus.u_instruction[23:20];
    assign offExt = {{16{bus.u_instruction[15]}}, bus.u_instruction[15:0]} & 32'hFFFF_FFFC;
    assign uPcInc = bus.uPC + 32'd4;

    always_comb begin
        taken = 1'b0;
        case (cond)
            4'h0:    taken = bus.flag_z;
            4'h1:    taken = bus.flag_n ^ bus.flag_v;
            4'h2:    taken = ~bus.flag_z;
            4'h3:    taken = ~(bus.flag_n ^ bus.flag_v);
            4'h4:    taken = bus.flag_c;
            4'h5:    taken = ~bus.flag_c;
            4'h6:    taken = bus.flag_n;
            4'h7:    taken = ~bus.flag_n;
            4'hF:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // uPC only moves on a handshake or a resolved branch, which keeps uop stable while stalled
    always_comb begin
        stateNext     = state;
        uPcNext       = bus.uPC;
        bus.uop_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dispatch_valid) begin
                    stateNext = RUN;
                    uPcNext   = bus.dispatch_entry & 32'hFFFF_FFFC;
                end
            end
            RUN: begin
                if (wdogHit) begin
                    stateNext = DONE;
                end else if (op == OP_UEND) begin
                    stateNext = DONE;
                end else if (op == OP_UBR) begin
                    if (bus.flags_valid) begin
                        uPcNext = taken ? (uPcInc + offExt) : uPcInc;
                    end
                end else begin
                    bus.uop_valid = 1'b1;
                    if (bus.uop_ready) begin
                        uPcNext = uPcInc;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bus.uPC <= '0;
        end else begin
            state   <= stateNext;
            bus.uPC <= uPcNext;
        end
    end

    assign bus.uop            = bus.u_instruction;
    assign bus.dispatch_ready = (state == IDLE);
    assign bus.busy           = (state == RUN) || (state == DONE);
    assign bus.done           = (state == DONE);

`ifdef USEQ_WATCHDOG_EN
    logic [31:0] wdogCnt;
    logic        errFlag;

    // Abort fires in the LIMIT-th RUN cycle so a routine never exceeds LIMIT RUN cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            wdogCnt <= '0;
            errFlag <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.dispatch_valid) begin
                wdogCnt <= '0;
                errFlag <= 1'b0;
            end else if (state == RUN) begin
                wdogCnt <= wdogCnt + 32'd1;
            end
            if (wdogHit) begin
                errFlag <= 1'b1;
            end
        end
    end

    assign wdogHit = (state == RUN) && (wdogCnt == 32'(WDOG_LIMIT - 1));
    assign bus.err = (state == DONE) && errFlag;
`else
    assign wdogHit = 1'b0;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq: ROM model, datapath flag model and a scoreboard
// of expected (uPC, uop) issues built by an instruction-level reference walk.
`timescale 1ns/1ps
module tb_useq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    useq_if bus();
    useq dut (.clk(clk), .rst(rst), .bus(bus.master));

`ifdef USEQ_WATCHDOG_EN
    useq_if wbus();
    useq #(.WDOG_LIMIT(16)) wdut (.clk(clk), .rst(rst), .bus(wbus.master));
    assign wbus.u_instruction = 32'hC2F0_FFFC;
`endif

    int checks;
    int errors;

    logic [31:0] romLo [0:63];
    logic [31:0] romHi;
    logic [63:0] expQ [$];
    logic [31:0] dpRegs [0:15];
    logic        dpZ, dpN, dpC, dpV;

    always_comb begin
        if (bus.uPC == 32'hFFFF_FFFC)  bus.u_instruction = romHi;
        else if (bus.uPC < 32'd256)    bus.u_instruction = romLo[bus.uPC[7:2]];
        else                           bus.u_instruction = 32'hD000_0000;
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'hFFFF_FFFC) return romHi;
        if (a < 32'd256) return romLo[a[7:2]];
        return 32'hD000_0000;
    endfunction

    function automatic logic cond_eval(input logic [3:0] c, input logic z, input logic n,
                                       input logic cf, input logic v);
        case (c)
            4'h0: return z;
            4'h1: return n != v;
            4'h2: return !z;
            4'h3: return n == v;
            4'h4: return cf;
            4'h5: return !cf;
            4'h6: return n;
            4'h7: return !n;
            4'hF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 64; i++) romLo[i] = 32'hD000_0000;
        romHi = 32'hD000_0000;
    endtask

    task automatic dp_clear();
        for (int i = 0; i < 16; i++) dpRegs[i] = '0;
        {dpZ, dpN, dpC, dpV} = 4'b0000;
    endtask

    // Toy datapath: MOV imm, AND imm, SHR imm, TEST (sets Z/N), everything else ADD imm
    task automatic dp_exec(input logic [31:0] w);
        logic [3:0]  rd, rs;
        logic [31:0] imm;
        rd  = w[23:20];
        rs  = w[19:16];
        imm = {16'h0, w[15:0]};
        case (w[31:24])
            8'h00: dpRegs[rd] = imm;
            8'h26: dpRegs[rd] = dpRegs[rs] & imm;
            8'h0A: dpRegs[rd] = dpRegs[rs] >> imm[4:0];
            8'h35: begin
                dpZ = (dpRegs[rs] == 32'h0);
                dpN = dpRegs[rs][31];
                dpC = 1'b0;
                dpV = 1'b0;
            end
            default: dpRegs[rd] = dpRegs[rs] + imm;
        endcase
    endtask

    task automatic iss_run(input logic [31:0] entry);
        logic [31:0] pc, w, off;
        pc = entry & 32'hFFFF_FFFC;
        for (int i = 0; i < 500; i++) begin
            w = rom_word(pc);
            if (w[31:24] == 8'hD0) break;
            if (w[31:24] == 8'hC2) begin
                off = {{16{w[15]}}, w[15:2], 2'b00};
                pc  = pc + 32'd4 + (cond_eval(w[23:20], dpZ, dpN, dpC, dpV) ? off : 32'd0);
            end else begin
                expQ.push_back({pc, w});
                dp_exec(w);
                pc = pc + 32'd4;
            end
        end
    endtask

    task automatic dispatch(input logic [31:0] entry);
        @(negedge clk);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = entry;
        @(negedge clk);
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.dispatch_ready); end
        checks++; if (bus.uPC !== 32'h0) begin errors++; $display("FAIL reset_uPC: got %h expected 0", bus.uPC); end
        checks++; if (bus.uop_valid !== 1'b0) begin errors++; $display("FAIL reset_uop_valid: got %b expected 0", bus.uop_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_mul();
        logic [31:0] words [0:12];
        logic [31:0] prevPc;
        logic [63:0] e;
        int doneCnt, loops;
        bit fin;
        words = '{32'h22200000, 32'h04400000, 32'h0060000A, 32'h26860001, 32'h35C80000,
                  32'hC2000008, 32'h62442000, 32'h08220001, 32'h0A660001, 32'h35C60000,
                  32'hC220FFE4, 32'h22040000, 32'hD0000000};
        rom_clear();
        for (int i = 0; i < 13; i++) romLo[i] = words[i];
        expQ.delete();
        dp_clear();
        iss_run(32'h0);
        dp_clear();
        {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = 4'b0000;
        bus.uop_ready   = 1'b1;
        bus.flags_valid = 1'b1;
        doneCnt = 0; loops = 0; fin = 1'b0; prevPc = 32'hFFFF_FFFF;
        dispatch(32'h0);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (prevPc == 32'h28 && bus.uPC == 32'h10) loops++;
            prevPc = bus.uPC;
            if (bus.uop_valid === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("FAIL mul_extra_uop: got uPC %h uop %h expected none", bus.uPC, bus.uop);
                end else begin
                    e = expQ.pop_front();
                    if ({bus.uPC, bus.uop} !== e) begin
                        errors++; $display("FAIL mul_uop: got %h/%h expected %h/%h", bus.uPC, bus.uop, e[63:32], e[31:0]);
                    end
                end
                dp_exec(bus.uop);
                {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = {dpZ, dpN, dpC, dpV};
            end
            if (bus.done === 1'b1) begin
                doneCnt++;
                checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mul_err: got %b expected 0", bus.err); end
            end
            if (doneCnt > 0 && bus.dispatch_ready === 1'b1) fin = 1'b1;
        end
        checks++; if (!fin) begin errors++; $display("FAIL mul_timeout: got busy expected idle"); end
        checks++; if (expQ.size() != 0) begin errors++; $display("FAIL mul_missing: got %0d left expected 0", expQ.size()); end
        checks++; if (doneCnt != 1) begin errors++; $display("FAIL mul_done_count: got %0d expected 1", doneCnt); end
        checks++; if (loops != 3) begin errors++; $display("FAIL mul_loopbacks: got %0d expected 3", loops); end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        bit seenDone;
        rom_clear();
        romLo[0] = 32'hA0000001; romLo[1] = 32'hA0000002; romLo[2] = 32'hA0000003;
        expQ.delete();
        expQ.push_back({32'h0, 32'hA0000001});
        expQ.push_back({32'h4, 32'hA0000002});
        expQ.push_back({32'h8, 32'hA0000003});
        bus.uop_ready = 1'b0;
        dispatch(32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.uop_valid !== 1'b1 || bus.uPC !== 32'h0 || bus.uop !== 32'hA0000001) begin
                errors++; $display("FAIL bp_stall%0d: got v=%b uPC=%h uop=%h expected 1/0/a0000001", i, bus.uop_valid, bus.uPC, bus.uop);
            end
            @(negedge clk);
        end
        bus.uop_ready = 1'b1;
        seenDone = 1'b0;
        for (int cyc = 0; cyc < 20 && !seenDone; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if (bus.uop_valid !== 1'b1 || bus.uPC !== 32'h4) begin
                    errors++; $display("FAIL bp_next: got v=%b uPC=%h expected 1/4", bus.uop_valid, bus.uPC);
                end
            end
            if (bus.uop_valid === 1'b1 && expQ.size() != 0) begin
                e = expQ.pop_front();
                checks++;
                if ({bus.uPC, bus.uop} !== e) begin
                    errors++; $display("FAIL bp_uop: got %h/%h expected %h/%h", bus.uPC, bus.uop, e[63:32], e[31:0]);
                end
            end
            if (bus.done === 1'b1) seenDone = 1'b1;
        end
        checks++; if (!seenDone || expQ.size() != 0) begin errors++; $display("FAIL bp_end: got done=%b left=%0d expected 1/0", seenDone, expQ.size()); end
        @(negedge clk);
    endtask

    task automatic test_flag_stall();
        rom_clear();
        romLo[0] = 32'h00100005;
        romLo[1] = 32'hC2000008;
        bus.uop_ready = 1'b1;
        bus.flags_valid = 1'b1;
        {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = 4'b0000;
        dispatch(32'h0);
        checks++; if (bus.uPC !== 32'h0 || bus.uop_valid !== 1'b1) begin errors++; $display("FAIL fs_first: got uPC=%h v=%b expected 0/1", bus.uPC, bus.uop_valid); end
        bus.flags_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.uPC !== 32'h4 || bus.uop_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL fs_hold%0d: got uPC=%h v=%b busy=%b expected 4/0/1", i, bus.uPC, bus.uop_valid, bus.busy);
            end
        end
        bus.flag_z = 1'b1;
        bus.flags_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.uPC !== 32'h10) begin errors++; $display("FAIL fs_resolve: got %h expected 10", bus.uPC); end
        for (int i = 0; i < 10 && bus.dispatch_ready !== 1'b1; i++) @(negedge clk);
        checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL fs_idle: got %b expected 1", bus.dispatch_ready); end
    endtask

    task automatic test_branch_edges();
        logic [3:0]  c, f, fr;
        logic [31:0] want;
        rom_clear();
        romLo[0] = 32'hC2F0FFFC;
        bus.flags_valid = 1'b1;
        dispatch(32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.uPC !== 32'h0 || bus.uop_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++; $display("FAIL br_selfloop%0d: got uPC=%h v=%b busy=%b expected 0/0/1", i, bus.uPC, bus.uop_valid, bus.busy);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        fr = 4'h0;
        romLo[1] = 32'hD0000000;
        romLo[5] = 32'hD0000000;
        for (int k = 0; k < 32; k++) begin
            c = 4'(k / 2);
            if (k % 2 == 0) fr = 4'($urandom_range(0, 15));
            f = (k % 2 == 1) ? ~fr : fr;
            {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = f;
            romLo[0] = {8'hC2, c, 4'h0, 16'h0010};
            want = cond_eval(c, f[3], f[2], f[1], f[0]) ? 32'h14 : 32'h4;
            dispatch(32'h0);
            checks++; if (bus.uPC !== 32'h0) begin errors++; $display("FAIL br_entry c=%h: got %h expected 0", c, bus.uPC); end
            @(negedge clk);
            checks++; if (bus.uPC !== want) begin errors++; $display("FAIL br_cond c=%h zncv=%b: got %h expected %h", c, f, bus.uPC, want); end
            for (int i = 0; i < 10 && bus.dispatch_ready !== 1'b1; i++) @(negedge clk);
        end

        rom_clear();
        romHi = 32'h11000000;
        bus.uop_ready = 1'b1;
        dispatch(32'hFFFF_FFFF);
        checks++;
        if (bus.uPC !== 32'hFFFF_FFFC || bus.uop_valid !== 1'b1 || bus.uop !== 32'h11000000) begin
            errors++; $display("FAIL br_wrap_entry: got uPC=%h v=%b uop=%h expected fffffffc/1/11000000", bus.uPC, bus.uop_valid, bus.uop);
        end
        @(negedge clk);
        checks++; if (bus.uPC !== 32'h0) begin errors++; $display("FAIL br_wrap: got %h expected 0", bus.uPC); end
        for (int i = 0; i < 10 && bus.dispatch_ready !== 1'b1; i++) @(negedge clk);
        checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL br_idle: got %b expected 1", bus.dispatch_ready); end
    endtask

    task automatic test_reset_mid();
        rom_clear();
        romLo[0] = 32'hA0000001;
        romLo[1] = 32'hA0000002;
        bus.uop_ready = 1'b1;
        dispatch(32'h0);
        @(negedge clk);
        bus.uop_ready = 1'b0;
        checks++; if (bus.uop_valid !== 1'b1 || bus.uPC !== 32'h4) begin errors++; $display("FAIL rm_pre: got v=%b uPC=%h expected 1/4", bus.uop_valid, bus.uPC); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.uop_valid !== 1'b0) begin errors++; $display("FAIL rm_uop_valid: got %b expected 0", bus.uop_valid); end
        checks++; if (bus.uPC !== 32'h0) begin errors++; $display("FAIL rm_uPC: got %h expected 0", bus.uPC); end
        checks++; if (bus.dispatch_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rm_idle: got ready=%b busy=%b expected 1/0", bus.dispatch_ready, bus.busy); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int doneCnt;
        bit prevUend, prevDone;
        rom_clear();
        romLo[0] = 32'hA0000001;
        bus.uop_ready = 1'b1;
        doneCnt = 0; prevUend = 1'b0; prevDone = 1'b0;
        @(negedge clk);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_entry = 32'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (prevUend) begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done_lat: got %b expected 1", bus.done); end
            end
            if (prevDone) begin
                checks++; if (bus.dispatch_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_lat: got %b expected 1", bus.dispatch_ready); end
            end
            if (bus.done === 1'b1) doneCnt++;
            prevUend = (bus.busy === 1'b1) && (bus.done === 1'b0) && (bus.u_instruction[31:24] == 8'hD0);
            prevDone = (bus.done === 1'b1);
        end
        bus.dispatch_valid = 1'b0;
        checks++; if (doneCnt != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", doneCnt); end
        for (int i = 0; i < 10 && bus.dispatch_ready !== 1'b1; i++) @(negedge clk);
    endtask

`ifdef USEQ_WATCHDOG_EN
    task automatic test_watchdog();
        @(negedge clk);
        wbus.dispatch_valid = 1'b1;
        @(negedge clk);
        wbus.dispatch_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) @(negedge clk);
            checks++;
            if (wbus.busy !== 1'b1 || wbus.done !== 1'b0) begin
                errors++; $display("FAIL wd_run%0d: got busy=%b done=%b expected 1/0", i, wbus.busy, wbus.done);
            end
        end
        @(negedge clk);
        checks++; if (wbus.done !== 1'b1 || wbus.err !== 1'b1) begin errors++; $display("FAIL wd_abort: got done=%b err=%b expected 1/1", wbus.done, wbus.err); end
        @(negedge clk);
        checks++; if (wbus.dispatch_ready !== 1'b1 || wbus.done !== 1'b0) begin errors++; $display("FAIL wd_idle: got ready=%b done=%b expected 1/0", wbus.dispatch_ready, wbus.done); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_entry = '0;
        bus.uop_ready = 1'b0;
        bus.flags_valid = 1'b0;
        {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = 4'b0000;
`ifdef USEQ_WATCHDOG_EN
        wbus.dispatch_valid = 1'b0;
        wbus.dispatch_entry = '0;
        wbus.uop_ready = 1'b1;
        wbus.flags_valid = 1'b1;
        {wbus.flag_z, wbus.flag_n, wbus.flag_c, wbus.flag_v} = 4'b0000;
`endif
        rom_clear();
        dp_clear();
        test_reset();
        test_mul();
        test_backpressure();
        test_flag_stall();
        test_branch_edges();
        test_reset_mid();
        test_back_to_back();
`ifdef USEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
